// File: rtl/rr_arb_4_way_16_pkg.sv
// Shared constants and types for the 4-way round-robin arbiter slice.
package rr_arb_4_way_16_pkg;

   localparam int unsigned RR_WIDTH   = 16;
   localparam int unsigned RR_NUM_SRC = 4;
   localparam int unsigned RR_SEL_W   = 2;

   typedef logic [RR_SEL_W-1:0]   rr_idx_t;
   typedef logic [RR_NUM_SRC-1:0] rr_vec_t;

   localparam rr_idx_t RR_LAST_RESET = 2'b11;

   function automatic rr_vec_t rr_onehot(input rr_idx_t idx);
      rr_vec_t v;
      v = '0;
      v[idx] = 1'b1;
      return v;
   endfunction

endpackage

// File: rtl/Mux_4_Way_16.sv
// Existing 4-way word multiplexer; sel picks a, b, c or d.
module Mux_4_Way_16 #(
   parameter int unsigned WIDTH = 16
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [WIDTH-1:0] c,
   input  logic [WIDTH-1:0] d,
   input  logic [1:0]       sel,
   output logic [WIDTH-1:0] out
);

   always_comb begin
      out = a;
      unique case (sel)
         2'd0: out = a;
         2'd1: out = b;
         2'd2: out = c;
         2'd3: out = d;
         default: out = a;
      endcase
   end

endmodule

// File: rtl/rr_pick_4.sv
// Combinational round-robin search: first set req bit after `last`, wrapping.
module rr_pick_4
   import rr_arb_4_way_16_pkg::*;
(
   input  rr_vec_t req,
   input  rr_idx_t last,
   output rr_idx_t w,
   output logic    any
);

   rr_idx_t idx;

   // Offsets 1..4 from last; offset 4 wraps back to last itself.
   always_comb begin
      w   = last;
      any = 1'b0;
      idx = last;
      for (int unsigned k = 1; k <= RR_NUM_SRC; k++) begin
         idx = last + RR_SEL_W'(k);
         if (!any && req[idx]) begin
            w   = idx;
            any = 1'b1;
         end
      end
   end

endmodule

// File: rtl/rr_arb_4_way_16.sv
// Round-robin arbiter feeding Mux_4_Way_16 into a valid/ready output register.
module rr_arb_4_way_16
   import rr_arb_4_way_16_pkg::*;
#(
   parameter int unsigned WIDTH = RR_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [WIDTH-1:0] c,
   input  logic [WIDTH-1:0] d,
   input  logic [3:0]       req,
   output logic [3:0]       grant,
   output logic [1:0]       select,
   output logic [WIDTH-1:0] out,
   output logic             out_valid,
   input  logic             out_ready
);

   rr_idx_t          last;
   rr_idx_t          w;
   logic             any;
   logic             can_load;
   logic             xfer;
   logic [WIDTH-1:0] mux_out;

   rr_pick_4 u_pick (
      .req  (req),
      .last (last),
      .w    (w),
      .any  (any)
   );

   Mux_4_Way_16 #(.WIDTH(WIDTH)) u_mux (
      .a   (a),
      .b   (b),
      .c   (c),
      .d   (d),
      .sel (select),
      .out (mux_out)
   );

   always_comb begin
      select   = w;
      can_load = !out_valid || out_ready;
      grant    = '0;
      if (any && can_load) begin
         grant = rr_onehot(w);
      end
      xfer = |grant;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out       <= '0;
         out_valid <= 1'b0;
         last      <= RR_LAST_RESET;
      end else if (xfer) begin
         out       <= mux_out;
         out_valid <= 1'b1;
         last      <= w;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_rr_arb_4_way_16.sv
// Bench for rr_arb_4_way_16: directed table, async reset sequence, random vs model.
module tb_rr_arb_4_way_16;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] a, b, c, d;
   logic [3:0]  req;
   logic [3:0]  grant;
   logic [1:0]  select;
   logic [15:0] out;
   logic        out_valid;
   logic        out_ready;

   int n_checks = 0;
   int n_fail   = 0;

   int          m_last;
   logic [15:0] m_out;
   bit          m_valid;
   logic [3:0]  g_seen;
   logic [1:0]  s_seen;

   typedef struct {
      logic [3:0]  r;
      logic        rdy;
      logic [3:0]  g;
      logic [1:0]  s;
      logic        v;
      logic [15:0] o;
   } vec_t;
   vec_t tbl[$];

   rr_arb_4_way_16 #(.WIDTH(16)) dut (
      .clk       (clk),
      .reset     (reset),
      .a         (a),
      .b         (b),
      .c         (c),
      .d         (d),
      .req       (req),
      .grant     (grant),
      .select    (select),
      .out       (out),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [15:0] dsel(input int i);
      case (i)
         0: return a;
         1: return b;
         2: return c;
         default: return d;
      endcase
   endfunction

   // Rotate req so the search starts at bit 0, take the lowest set bit, rotate back.
   function automatic int pick(input logic [3:0] r, input int lst);
      logic [7:0] dbl;
      logic [7:0] sh;
      logic [3:0] rot;
      logic [3:0] low;
      int base;
      base = (lst + 1) % 4;
      dbl  = {r, r};
      sh   = dbl >> base;
      rot  = sh[3:0];
      if (rot == 4'b0) return lst;
      low = rot & (~rot + 4'd1);
      return ($clog2(low) + base) % 4;
   endfunction

   task automatic model_reset();
      m_last  = 3;
      m_out   = 16'h0000;
      m_valid = 1'b0;
   endtask

   // Drive at posedge+1, check combinational outputs at negedge, registers at posedge+1.
   task automatic apply(input logic [3:0] r, input logic rdy, input string tag);
      int w;
      logic [3:0] eg;
      req       = r;
      out_ready = rdy;
      @(negedge clk);
      w  = pick(r, m_last);
      eg = (r != 4'b0 && (!m_valid || rdy)) ? (4'b0001 << w) : 4'b0000;
      g_seen = grant;
      s_seen = select;
      chk({tag, " grant"}, 32'(grant), 32'(eg));
      chk({tag, " select"}, 32'(select), 32'(w));
      @(posedge clk);
      #1;
      if (eg != 4'b0) begin
         m_out   = dsel(w);
         m_valid = 1'b1;
         m_last  = w;
      end else if (rdy) begin
         m_valid = 1'b0;
      end
      chk({tag, " out"}, 32'(out), 32'(m_out));
      chk({tag, " out_valid"}, 32'(out_valid), 32'(m_valid));
   endtask

   task automatic add(input logic [3:0] r, input logic rdy, input logic [3:0] g,
                      input logic [1:0] s, input logic v, input logic [15:0] o);
      vec_t e;
      e.r = r; e.rdy = rdy; e.g = g; e.s = s; e.v = v; e.o = o;
      tbl.push_back(e);
   endtask

   initial begin
      reset = 1'b1;
      req = 4'b0; out_ready = 1'b0;
      a = 16'h0001; b = 16'h1232; c = 16'h1111; d = 16'h1001;
      model_reset();

      // Idle after reset
      repeat (5) add(4'b0000, 1'b0, 4'b0000, 2'd3, 1'b0, 16'h0000);
      // Full rotation
      add(4'b1111, 1'b1, 4'b0001, 2'd0, 1'b1, 16'h0001);
      add(4'b1111, 1'b1, 4'b0010, 2'd1, 1'b1, 16'h1232);
      add(4'b1111, 1'b1, 4'b0100, 2'd2, 1'b1, 16'h1111);
      add(4'b1111, 1'b1, 4'b1000, 2'd3, 1'b1, 16'h1001);
      add(4'b1111, 1'b1, 4'b0001, 2'd0, 1'b1, 16'h0001);
      // Single requester
      repeat (3) add(4'b0100, 1'b1, 4'b0100, 2'd2, 1'b1, 16'h1111);
      // Stall with output full
      repeat (4) add(4'b1111, 1'b0, 4'b0000, 2'd3, 1'b1, 16'h1111);
      add(4'b1111, 1'b1, 4'b1000, 2'd3, 1'b1, 16'h1001);
      // Drain, then last=2 with req 0101 -> source 0
      add(4'b0000, 1'b1, 4'b0000, 2'd3, 1'b0, 16'h1001);
      add(4'b0100, 1'b1, 4'b0100, 2'd2, 1'b1, 16'h1111);
      add(4'b0101, 1'b1, 4'b0001, 2'd0, 1'b1, 16'h0001);
      add(4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0, 16'h0001);
      add(4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0, 16'h0001);

      @(posedge clk);
      #1;
      chk("reset out_valid", 32'(out_valid), 32'd0);
      chk("reset out", 32'(out), 32'd0);
      chk("reset grant", 32'(grant), 32'd0);
      chk("reset select", 32'(select), 32'd3);
      reset = 1'b0;
      @(posedge clk);
      #1;

      for (int i = 0; i < tbl.size(); i++) begin
         apply(tbl[i].r, tbl[i].rdy, $sformatf("vec%0d", i));
         chk($sformatf("vec%0d tbl_grant", i), 32'(g_seen), 32'(tbl[i].g));
         chk($sformatf("vec%0d tbl_select", i), 32'(s_seen), 32'(tbl[i].s));
         chk($sformatf("vec%0d tbl_valid", i), 32'(out_valid), 32'(tbl[i].v));
         chk($sformatf("vec%0d tbl_out", i), 32'(out), 32'(tbl[i].o));
      end

      // Asynchronous reset mid-cycle with a word held in the output register
      apply(4'b0100, 1'b0, "pre_rst");
      chk("pre_rst valid", 32'(out_valid), 32'd1);
      req = 4'b0000;
      #3 reset = 1'b1;
      #1;
      chk("async_rst out_valid", 32'(out_valid), 32'd0);
      chk("async_rst out", 32'(out), 32'd0);
      chk("async_rst select", 32'(select), 32'd3);
      model_reset();
      #2 reset = 1'b0;
      @(posedge clk);
      #1;
      apply(4'b1000, 1'b1, "post_rst");
      chk("post_rst grant", 32'(g_seen), 32'h8);
      chk("post_rst out", 32'(out), 32'h1001);
      chk("post_rst valid", 32'(out_valid), 32'd1);

      // Random traffic; ungranted sources hold req and data
      for (int n = 0; n < 400; n++) begin
         logic [3:0]  hold;
         logic [3:0]  r;
         logic        rdy;
         hold = req & ~g_seen;
         r    = hold | 4'($urandom_range(0, 15));
         if (!hold[0]) a = 16'($urandom);
         if (!hold[1]) b = 16'($urandom);
         if (!hold[2]) c = 16'($urandom);
         if (!hold[3]) d = 16'($urandom);
         rdy = ($urandom_range(0, 3) != 0);
         apply(r, rdy, $sformatf("rnd%0d", n));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
